// File: rtl/led_driver.sv
// LED output stage: period-aligned PWM brightness on a registered pattern, plus
// a restartable acknowledge flash burst that overrides the display while it runs.
module led_driver #(
  parameter int WIDTH      = 4,
  parameter int PWM_BITS   = 8,
  parameter int TIMER_BITS = 22,
  parameter int FLASH_LEN  = 2000000,
  parameter int N_BLINKS   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                flash,
  output logic [WIDTH-1:0]    led,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [TIMER_BITS-1:0] PHASE_LAST  = TIMER_BITS'(FLASH_LEN - 1);
  localparam logic [3:0]            BLINKS_LAST = 4'(N_BLINKS - 1);

  state_t                state;
  logic [TIMER_BITS-1:0] timer;
  logic [3:0]            rem;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   bright_q;
  logic [WIDTH-1:0]      pat_q;
  logic                  pwm_on;

  assign pwm_on = (pwm_cnt < bright_q);
  assign busy   = (state != IDLE);

  // Brightness is only sampled on the last count so every period has one duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
      pat_q    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pat_q   <= pattern;
      if (&pwm_cnt) begin
        bright_q <= brightness;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      rem   <= '0;
      led   <= '0;
    end else begin
      case (state)
        ON:      led <= '1;
        OFF:     led <= '0;
        default: led <= pat_q & {WIDTH{pwm_on}};
      endcase

      // A strobe always restarts the burst, even mid-phase.
      if (flash) begin
        state <= ON;
        timer <= PHASE_LAST;
        rem   <= BLINKS_LAST;
      end else begin
        case (state)
          ON: begin
            if (timer == '0) begin
              state <= OFF;
              timer <= PHASE_LAST;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          OFF: begin
            if (timer == '0) begin
              if (rem == '0) begin
                state <= IDLE;
              end else begin
                state <= ON;
                rem   <= rem - 1'b1;
                timer <= PHASE_LAST;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a cycle-count reference model.
module tb_led_driver;

  localparam int W   = 4;
  localparam int PB  = 4;
  localparam int FL  = 4;
  localparam int NB  = 2;
  localparam int SEQ = 2 * NB * FL;
  localparam int PER = 1 << PB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flash = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [PB-1:0] brightness = '0;
  logic [W-1:0] led;
  logic         busy;

  led_driver #(
    .WIDTH(W), .PWM_BITS(PB), .TIMER_BITS(22), .FLASH_LEN(FL), .N_BLINKS(NB)
  ) dut (
    .clk(clk), .reset(reset), .pattern(pattern), .brightness(brightness),
    .flash(flash), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: the flash burst is tracked only as the age in cycles since
  // the last strobe; the phase is (age / FL), even phases are lit.
  int           m_cnt = 0;
  int           m_bright = 0;
  int           m_pat = 0;
  int           m_age = -1;
  logic [W-1:0] m_led = '0;
  logic         m_busy = 1'b0;

  task automatic model_edge();
    if (reset) begin
      m_cnt = 0; m_bright = 0; m_pat = 0; m_age = -1; m_led = '0;
    end else begin
      if (m_age >= 0) m_led = (((m_age / FL) % 2) == 0) ? 4'hF : 4'h0;
      else            m_led = (m_cnt < m_bright) ? 4'(m_pat) : 4'h0;
      if (m_cnt == PER - 1) m_bright = int'(brightness);
      m_cnt = (m_cnt + 1) % PER;
      m_pat = int'(pattern);
      if (flash) m_age = 0;
      else if (m_age >= 0) begin
        m_age++;
        if (m_age == SEQ) m_age = -1;
      end
    end
    m_busy = (m_age >= 0);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model_led", int'(led), int'(m_led));
    check("model_busy", int'(busy), int'(m_busy));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] pat;
    logic [PB-1:0] bri;
    logic         fl;
    logic [W-1:0] led;
    logic         busy;
  } vec_t;

  vec_t vec[20];

  int hi0, hi3, hiup, nbusy, nones;
  bit fell;

  initial begin
    // Reset, then one flash strobe with brightness 0 so the idle display is dark.
    vec[0]  = '{1'b1, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b0};
    vec[1]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b0};
    vec[2]  = '{1'b0, 4'b0001, 4'h0, 1'b1, 4'h0, 1'b1};
    vec[3]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[4]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[5]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[6]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[7]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[8]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[9]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[10] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[11] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[12] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[13] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[14] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'hF, 1'b1};
    vec[15] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[16] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[17] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b1};
    vec[18] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b0};
    vec[19] = '{1'b0, 4'b0001, 4'h0, 1'b0, 4'h0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      reset = vec[i].rst; pattern = vec[i].pat; brightness = vec[i].bri; flash = vec[i].fl;
      step();
      check($sformatf("vec%0d_led", i), int'(led), int'(vec[i].led));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vec[i].busy));
    end
    reset = 1'b0; flash = 1'b0; pattern = 4'b0001;

    // Full brightness: 15 of 16 cycles lit on led[0], upper bits dark.
    brightness = 4'hF;
    repeat (20) step();
    hi0 = 0; hiup = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      hi0 += int'(led[0]);
      hiup += int'(led[3:1] != 3'b000);
    end
    check("duty_full_led0", hi0, 30);
    check("duty_full_upper", hiup, 0);

    // Zero brightness stays dark, then a mid-period change to 8 gives 8/16.
    brightness = 4'h0;
    repeat (20) step();
    hi0 = 0;
    for (int i = 0; i < 2 * PER; i++) begin step(); hi0 += int'(led[0]); end
    check("duty_zero", hi0, 0);
    repeat (5) step();
    brightness = 4'h8;
    repeat (PER + 1) step();
    hi0 = 0;
    for (int i = 0; i < PER; i++) begin step(); hi0 += int'(led[0]); end
    check("duty_half", hi0, 8);

    // Restart: second strobe six cycles into a burst.
    flash = 1'b1; step(); flash = 1'b0;
    repeat (5) step();
    flash = 1'b1; step(); flash = 1'b0;
    nbusy = int'(busy); nones = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      nbusy += int'(busy);
      if (i <= FL) nones += int'(led == 4'hF);
    end
    check("restart_busy_len", nbusy, SEQ);
    check("restart_on_cycles", nones, FL);

    // Reset during an ON phase clears everything on the next edge.
    flash = 1'b1; step(); flash = 1'b0;
    repeat (2) step();
    reset = 1'b1; step();
    check("rst_mid_led", int'(led), 0);
    check("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin step(); nbusy += int'(busy); end
    check("rst_no_activity", nbusy, 0);

    // Pattern moves during a burst; display resumes with the new pattern.
    pattern = 4'b0001; brightness = 4'hF;
    flash = 1'b1; step(); flash = 1'b0;
    repeat (3) step();
    pattern = 4'b1000;
    fell = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin step(); if (!busy) fell = 1'b1; end
    check("pat_busy_fell", int'(fell), 1);
    repeat (PER + 1) step();
    hi0 = 0; hi3 = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      hi0 += int'(led[0]);
      hi3 += int'(led[3]);
    end
    check("pat_led0_dark", hi0, 0);
    check("pat_led3_pwm", hi3, 15);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(49) == 0);
      flash = ($urandom_range(19) == 0);
      if ($urandom_range(7) == 0) pattern = W'($urandom);
      if ($urandom_range(15) == 0) brightness = PB'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_driver.md
# led_driver

Output-side counterpart to the button debouncer: where the debouncer turns a noisy human input into a clean internal state, this block turns a clean internal position pattern into a human-visible LED signal. It applies a glitch-free PWM brightness setting and can run an acknowledge flash sequence, a burst of full-on/full-off blinks, on a single-cycle strobe. It sits between the position logic and the board LED pins.

## Interface
- WIDTH, 4: number of LEDs driven.
- PWM_BITS, 8: PWM counter / brightness width; PWM period = 2^PWM_BITS cycles.
- TIMER_BITS, 22: width of the flash phase timer.
- FLASH_LEN, 2000000: cycles per flash phase (ON or OFF); legal range 1 to 2^TIMER_BITS.
- N_BLINKS, 3: ON/OFF pairs per flash sequence; legal range 1 to 15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pattern  in  WIDTH  LED pattern to display, e.g. a one-hot position.
- brightness  in  PWM_BITS  duty setting; 0 = off, all-ones = (2^PWM_BITS−1)/2^PWM_BITS.
- flash  in  1  single-cycle strobe that starts or restarts a flash sequence.
- led  out  WIDTH  registered LED drive, active-high.
- busy  out  1  high while a flash sequence runs.

## Operation
- pat_q registers pattern every cycle.
- PWM counter pwm_cnt is free-running, PWM_BITS wide, +1 per cycle, wraps from all-ones to 0.
- bright_q loads brightness only in the cycle where pwm_cnt == all-ones. New duty therefore takes effect at a period boundary, so there are no partial periods.
- pwm_on = (pwm_cnt < bright_q), unsigned compare.
- State machine with states IDLE, ON and OFF. It also holds a timer (TIMER_BITS) and a blinks-remaining counter rem (4 bits).
  - flash=1 in any state: next state ON, timer ← FLASH_LEN−1, rem ← N_BLINKS−1. This applies while busy too: a strobe restarts the sequence and never extends or queues it.
  - ON, timer==0: → OFF, timer ← FLASH_LEN−1.
  - OFF, timer==0, rem==0: → IDLE.
  - OFF, timer==0, rem≠0: → ON, rem ← rem−1, timer ← FLASH_LEN−1.
  - Otherwise, in ON or OFF: timer ← timer−1.
  - flash has priority over every timer transition in the same cycle.
- led register next value, chosen by the current state:
  - IDLE: pat_q & {WIDTH{pwm_on}}.
  - ON: all ones, ignoring brightness and pattern.
  - OFF: all zeros.
- busy = (state != IDLE), decoded from the state register.
- Pattern and brightness changes during a flash are still tracked: pat_q and bright_q update, and the display resumes with current values on return to IDLE.

## Timing
- Reset values: led=0, busy=0, state=IDLE, pwm_cnt=0, bright_q=0, pat_q=0, timer=0, rem=0.
- Reset asserted mid-sequence: IDLE and all-zero outputs on the next edge. flash is ignored while reset is high.
- Pattern latency: a change on pattern at edge t reaches led at edge t+2, gated by pwm_on.
- Flash latency: strobe sampled at edge t → busy=1 and state ON after t; led all-ones after t+1.
- Each ON and OFF phase lasts exactly FLASH_LEN cycles. A full sequence lasts 2·N_BLINKS·FLASH_LEN cycles from the first ON cycle to the return to IDLE.
- FLASH_LEN=1: every phase is one cycle and the timer never decrements.
- Brightness latency: a write lands in bright_q at the next pwm_cnt wrap, up to 2^PWM_BITS cycles later.
- Duty: with bright_q=b, led is high for exactly b of every 2^PWM_BITS cycles in IDLE.

## Test plan
Benches override PWM_BITS=4, FLASH_LEN=4, N_BLINKS=2.
- Reset, then pattern=4'b0001, brightness=4'hF: led[0] high 15 of every 16 cycles and low on the cycle after pwm_cnt==15; led[3:1]=0.
- brightness=0: led stays 0 for ≥32 cycles. Change to 4'h8 mid-period: the duty stays 0 until the period boundary, then led[0] is high for exactly 8 of 16 cycles.
- Single flash pulse: busy high for exactly 16 cycles. led = 1111 ×4, 0000 ×4, 1111 ×4, 0000 ×4, then back to the PWM'd pattern.
- Second flash pulse 6 cycles into a sequence: the sequence restarts, led=1111 for the next 4 cycles, and busy stays high for 16 cycles after the second strobe.
- Reset asserted during an ON phase: next cycle led=0, busy=0. After release, no flash activity until a new strobe.
- pattern changed 0001→1000 during a flash: after busy falls, led[3] carries the PWM output and led[0]=0.
